tx_parsar_arbiter: RTL and testbench

Round-robin scheduler that shares the single `Output_Parsar` 128-bit-to-32-bit transmit path among up to `NUM_SRC` chunk producers. Each producer requests with a 128-bit chunk. The arbiter grants one source at a time and presents its chunks to the parser using the parser's `data_ready`/`Parsar_busy` handshake. It enforces a per-grant burst limit, gates new chunks on TX FIFO almost-full, and recovers from a parser that never goes busy. It sits directly upstream of `Output_Parsar`.

---
 rtl/tx_parsar_arbiter.sv | 217 +++++++++++++++++++++
 tb/tb_tx_parsar_arbiter.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_parsar_arbiter.sv
// -----------------------------------------------------------------------------
// tx_parsar_arbiter
//   Round-robin scheduler sharing the single Output_Parsar 128->32 transmit
//   path among NUM_SRC chunk producers. One source owns the parser at a time.
//   While it owns the parser, its chunks are presented one by one using the
//   parser's data_ready / Parsar_busy handshake. A grant ends on the last chunk,
//   after BURST_MAX chunks, when the source drops its request, or when the TX
//   FIFO is almost full. A presented chunk that never sees Parsar_busy is
//   aborted after TIMEOUT cycles.
//
// Ports
//   clk, rst             : clock, asynchronous active-high reset
//   src_req/last [N]     : per-source chunk valid / final chunk flag
//   src_data [N*128]     : source i chunk at [128*i +: 128]
//   src_ack [N]          : one-cycle pulse when source i's chunk is accepted
//   fifo_tx_almost_full  : blocks the start of a new chunk
//   Parsar_busy          : parser busy flag (acceptance handshake)
//   data_flat/data_ready : registered chunk and its valid to the parser
//   data_idle            : presented chunk is the last of its stream
//   grant_valid/grant_id : current owner of the parser
//   err_timeout          : one-cycle pulse on handshake abort
// -----------------------------------------------------------------------------
module tx_parsar_arbiter #(
  parameter int NUM_SRC   = 4,
  parameter int BURST_MAX = 16,
  parameter int TIMEOUT   = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_SRC-1:0]     src_req,
  input  logic [NUM_SRC*128-1:0] src_data,
  input  logic [NUM_SRC-1:0]     src_last,
  output logic [NUM_SRC-1:0]     src_ack,
  input  logic                   fifo_tx_almost_full,
  input  logic                   Parsar_busy,
  output logic [127:0]           data_flat,
  output logic                   data_ready,
  output logic                   data_idle,
  output logic                   grant_valid,
  output logic [2:0]             grant_id,
  output logic                   err_timeout
);

  localparam int BCW = $clog2(BURST_MAX + 1);
  localparam int TCW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PRESENT = 2'd1,
    S_WAIT    = 2'd2
  } state_t;

  state_t r_state, w_next;

  logic [2:0]         r_ptr;
  logic [2:0]         r_gid;
  logic [BCW-1:0]     r_burst;
  logic [TCW-1:0]     r_tcnt;
  logic [127:0]       r_data;
  logic               r_last;
  logic               r_gv;
  logic [NUM_SRC-1:0] r_ack;
  logic               r_tmo;

  // Sources padded to 8 so a 3-bit index is always in range.
  logic [7:0][127:0]  w_chunk8;
  logic [7:0]         w_req8;
  logic [7:0]         w_last8;

  for (genvar i = 0; i < 8; i++) begin : g_pad
    if (i < NUM_SRC) begin : g_src
      assign w_chunk8[i] = src_data[128*i +: 128];
      assign w_req8[i]   = src_req[i];
      assign w_last8[i]  = src_last[i];
    end else begin : g_nosrc
      assign w_chunk8[i] = '0;
      assign w_req8[i]   = 1'b0;
      assign w_last8[i]  = 1'b0;
    end
  end

  // Round-robin search starting at r_ptr, wrapping modulo NUM_SRC.
  logic       w_rr_found;
  logic [2:0] w_rr_sel;

  always_comb begin : rr_search
    int idx;
    idx        = 0;
    w_rr_found = 1'b0;
    w_rr_sel   = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      idx = (int'(r_ptr) + k) % NUM_SRC;
      if (!w_rr_found && w_req8[3'(idx)]) begin
        w_rr_found = 1'b1;
        w_rr_sel   = 3'(idx);
      end
    end
  end

  // Chunk source: fresh round-robin winner from IDLE, current owner otherwise.
  logic [2:0] w_src;
  logic       w_end_grant;
  logic [2:0] w_ptr_nxt;

  assign w_src       = (r_state == S_IDLE) ? w_rr_sel : r_gid;
  assign w_end_grant = r_last || (r_burst == BCW'(BURST_MAX)) ||
                       !w_req8[r_gid] || fifo_tx_almost_full;
  assign w_ptr_nxt   = (r_gid == 3'(NUM_SRC - 1)) ? 3'd0 : r_gid + 3'd1;

  logic w_load, w_accept, w_tmo, w_release;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next state and per-cycle action strobes
  always_comb begin
    w_next    = r_state;
    w_load    = 1'b0;
    w_accept  = 1'b0;
    w_tmo     = 1'b0;
    w_release = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!fifo_tx_almost_full && w_rr_found) begin
          w_load = 1'b1;
          w_next = S_PRESENT;
        end
      end
      S_PRESENT: begin
        // Acceptance has priority over a coincident timeout.
        if (Parsar_busy) begin
          w_accept = 1'b1;
          w_next   = S_WAIT;
        end else if (r_tcnt == TCW'(TIMEOUT - 1)) begin
          w_tmo     = 1'b1;
          w_release = 1'b1;
          w_next    = S_IDLE;
        end
      end
      S_WAIT: begin
        if (!Parsar_busy) begin
          if (w_end_grant) begin
            w_release = 1'b1;
            w_next    = S_IDLE;
          end else begin
            w_load = 1'b1;
            w_next = S_PRESENT;
          end
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs decoded from state; the state register's async reset drops
  // data_ready immediately.
  always_comb begin
    data_ready = (r_state == S_PRESENT);
  end

  logic [NUM_SRC-1:0] w_ack_nxt;
  always_comb begin
    w_ack_nxt = '0;
    for (int i = 0; i < NUM_SRC; i++)
      w_ack_nxt[i] = w_accept && (r_gid == 3'(i));
  end

  // Datapath / grant registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr   <= '0;
      r_gid   <= '0;
      r_burst <= '0;
      r_tcnt  <= '0;
      r_data  <= '0;
      r_last  <= 1'b0;
      r_gv    <= 1'b0;
      r_ack   <= '0;
      r_tmo   <= 1'b0;
    end else begin
      r_ack <= w_ack_nxt;
      r_tmo <= w_tmo;

      if (w_load) begin
        r_data <= w_chunk8[w_src];
        r_last <= w_last8[w_src];
        r_gid  <= w_src;
        r_gv   <= 1'b1;
        r_tcnt <= '0;
        // Burst count spans the whole grant, so only a new grant clears it.
        if (r_state == S_IDLE) r_burst <= '0;
      end else if (w_accept || w_tmo) begin
        r_tcnt <= '0;
      end else if (r_state == S_PRESENT) begin
        r_tcnt <= r_tcnt + TCW'(1);
      end

      if (w_accept) r_burst <= r_burst + BCW'(1);

      if (w_release) begin
        r_gv  <= 1'b0;
        r_ptr <= w_ptr_nxt;
      end
    end
  end

  assign src_ack     = r_ack;
  assign data_flat   = r_data;
  assign data_idle   = r_last;
  assign grant_valid = r_gv;
  assign grant_id    = r_gid;
  assign err_timeout = r_tmo;

endmodule

// File: tb/tb_tx_parsar_arbiter.sv
module tb_tx_parsar_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   src_req, src_last, src_ack;
  logic [511:0] src_data;
  logic         fifo_tx_almost_full;
  logic         Parsar_busy;
  logic [127:0] data_flat;
  logic         data_ready, data_idle, grant_valid, err_timeout;
  logic [2:0]   grant_id;

  int errors = 0;
  int checks = 0;

  tx_parsar_arbiter #(.NUM_SRC(4), .BURST_MAX(3), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .src_req(src_req), .src_data(src_data), .src_last(src_last),
    .src_ack(src_ack),
    .fifo_tx_almost_full(fifo_tx_almost_full),
    .Parsar_busy(Parsar_busy),
    .data_flat(data_flat), .data_ready(data_ready), .data_idle(data_idle),
    .grant_valid(grant_valid), .grant_id(grant_id), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] mkdata(input int i, input int c);
    mkdata = {8'hA0 | 8'(i), 104'h0, 8'(i), 8'(c)};
  endfunction

  // ---------------- source model: advances on its ack pulse -----------------
  int s_cnt[4];
  int s_n[4];
  int s_mode[4];   // 0: never last, 1: last on final chunk, 2: last every chunk
  bit s_act[4];

  always_comb begin
    src_req  = '0;
    src_last = '0;
    src_data = '0;
    for (int i = 0; i < 4; i++) begin
      src_req[i]  = s_act[i];
      src_last[i] = (s_mode[i] == 2) || (s_mode[i] == 1 && s_cnt[i] == s_n[i] - 1);
      src_data[128*i +: 128] = mkdata(i, s_cnt[i]);
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++)
      if (src_ack[i]) begin
        s_cnt[i] = s_cnt[i] + 1;
        if (s_cnt[i] == s_n[i]) s_act[i] = 1'b0;
      end
  end

  // ---------------- parser model: busy for 4 cycles per chunk ----------------
  bit p_en;
  int bcnt;
  always @(negedge clk) begin
    if (rst) begin
      Parsar_busy = 1'b0;
      bcnt = 0;
    end else if (bcnt != 0) begin
      if (bcnt == 1) Parsar_busy = 1'b0;
      bcnt = bcnt - 1;
    end else if (data_ready && p_en) begin
      Parsar_busy = 1'b1;
      bcnt = 4;
    end
  end

  // ---------------- monitor ----------------
  int ack_q[$];
  int idle_q[$];
  int chk_q[$];
  int tmo_cnt, rel_cnt, viol, ovl;
  logic prev_gv = 1'b0;
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++)
      if (src_ack[i]) begin
        ack_q.push_back(i);
        idle_q.push_back(int'(data_idle));
        chk_q.push_back(int'(data_flat[7:0]));
      end
    if (err_timeout) tmo_cnt++;
    if (prev_gv && !grant_valid) rel_cnt++;
    prev_gv = grant_valid;
    if (data_ready && Parsar_busy) begin
      ovl++;
      if (ovl >= 2) viol++;
    end else ovl = 0;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_mon();
    ack_q.delete();
    idle_q.delete();
    chk_q.delete();
    tmo_cnt = 0;
    rel_cnt = 0;
  endtask

  task automatic start_src(input int i, input int n, input int mode);
    s_cnt[i]  = 0;
    s_n[i]    = n;
    s_mode[i] = mode;
    s_act[i]  = 1'b1;
  endtask

  task automatic wait_acks(input int n, input int lim, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < lim; k++) begin
      tick();
      if (ack_q.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_idle(input string tag);
    int quiet;
    quiet = 0;
    for (int k = 0; k < 400 && quiet < 3; k++) begin
      tick();
      if (!grant_valid && !data_ready && !Parsar_busy) quiet++;
      else quiet = 0;
    end
    checks++;
    if (quiet < 3) begin
      errors++;
      $display("FAIL %s_idle: arbiter still active gv=%0b dr=%0b, required quiet", tag, grant_valid, data_ready);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    p_en = 1'b1;
    fifo_tx_almost_full = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s_act[i] = 1'b0; s_cnt[i] = 0; s_n[i] = 1; s_mode[i] = 1;
    end
    repeat (3) tick();
    checks++;
    if ({data_ready, grant_valid, data_idle, err_timeout} !== 4'b0) begin
      errors++;
      $display("FAIL reset_flags: got dr/gv/idle/tmo=%b, required 0000",
               {data_ready, grant_valid, data_idle, err_timeout});
    end
    checks++;
    if (src_ack !== 4'b0) begin
      errors++; $display("FAIL reset_ack: got %b, required 0000", src_ack);
    end
    checks++;
    if (data_flat !== 128'h0) begin
      errors++; $display("FAIL reset_data: got %h, required 0", data_flat);
    end
    checks++;
    if (grant_id !== 3'd0) begin
      errors++; $display("FAIL reset_gid: got %0d, required 0", grant_id);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    bit ok, good;
    clear_mon();
    start_src(0, 4, 1);
    tick();
    checks++;
    if (data_ready !== 1'b1 || grant_id !== 3'd0 || data_idle !== 1'b0) begin
      errors++;
      $display("FAIL single_latency: dr=%b gid=%0d idle=%b, required 1 0 0", data_ready, grant_id, data_idle);
    end
    checks++;
    if (data_flat !== mkdata(0, 0)) begin
      errors++; $display("FAIL single_data0: got %h, required %h", data_flat, mkdata(0, 0));
    end
    wait_acks(4, 200, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL single_acks: got %0d acks, required 4", ack_q.size());
    end
    for (int k = 0; k < 20 && Parsar_busy; k++) tick();
    checks++;
    if (grant_valid !== 1'b1) begin
      errors++; $display("FAIL single_gv_at_fall: got %b, required 1", grant_valid);
    end
    tick();
    checks++;
    if (grant_valid !== 1'b0) begin
      errors++; $display("FAIL single_gv_after_fall: got %b, required 0", grant_valid);
    end
    good = (ack_q.size() == 4);
    for (int k = 0; k < ack_q.size(); k++)
      if (ack_q[k] != 0 || chk_q[k] != k || idle_q[k] != ((k == 3) ? 1 : 0)) good = 1'b0;
    checks++;
    if (!good) begin
      errors++;
      $display("FAIL single_stream: %0d acks %p chunks %p idle %p, required 4 acks of src0 chunks 0..3 idle 0001",
               ack_q.size(), ack_q, chk_q, idle_q);
    end
    // Pointer now 1: with sources 0 and 1 both requesting, 1 must win.
    clear_mon();
    start_src(0, 1, 1);
    start_src(1, 1, 1);
    wait_acks(2, 200, ok);
    checks++;
    if (!ok || ack_q[0] != 1 || ack_q[1] != 0) begin
      errors++; $display("FAIL single_ptr: order %p, required 1 then 0", ack_q);
    end
    wait_idle("single");
  endtask

  task automatic test_contention();
    bit ok, good;
    clear_mon();
    start_src(0, 2, 2);
    start_src(2, 2, 2);
    wait_acks(4, 300, ok);
    checks++;
    if (!ok || ack_q[0] != 2 || ack_q[1] != 0 || ack_q[2] != 2 || ack_q[3] != 0) begin
      errors++; $display("FAIL contention_order: got %p, required 2 0 2 0", ack_q);
    end
    good = 1'b1;
    for (int k = 1; k < ack_q.size(); k++) if (ack_q[k] == ack_q[k-1]) good = 1'b0;
    checks++;
    if (!good) begin
      errors++; $display("FAIL contention_repeat: got %p, required no repeated source", ack_q);
    end
    wait_idle("contention");
  endtask

  task automatic test_burst();
    bit ok, good;
    int c1;
    clear_mon();
    start_src(1, 10, 0);
    wait_acks(1, 100, ok);
    start_src(3, 1, 1);
    wait_acks(11, 1500, ok);
    checks++;
    if (!ok || ack_q[0] != 1 || ack_q[1] != 1 || ack_q[2] != 1 || ack_q[3] != 3) begin
      errors++; $display("FAIL burst_rotate: got %p, required 1 1 1 3 first", ack_q);
    end
    good = 1'b1;
    c1 = 0;
    for (int k = 0; k < ack_q.size(); k++)
      if (ack_q[k] == 1) begin
        if (chk_q[k] != c1) good = 1'b0;
        c1++;
      end
    checks++;
    if (!good || c1 != 10) begin
      errors++; $display("FAIL burst_src1: got %0d chunks %p, required 10 in order", c1, chk_q);
    end
    wait_idle("burst");
    checks++;
    if (rel_cnt != 5) begin
      errors++; $display("FAIL burst_releases: got %0d, required 5", rel_cnt);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int hi;
    clear_mon();
    start_src(0, 4, 1);
    wait_acks(2, 200, ok);
    fifo_tx_almost_full = 1'b1;
    for (int k = 0; k < 20 && Parsar_busy; k++) tick();
    tick();
    checks++;
    if (grant_valid !== 1'b0) begin
      errors++; $display("FAIL bp_release: gv got %b, required 0", grant_valid);
    end
    hi = 0;
    repeat (8) begin
      tick();
      if (data_ready) hi++;
    end
    checks++;
    if (hi != 0) begin
      errors++; $display("FAIL bp_hold: data_ready high %0d cycles, required 0", hi);
    end
    fifo_tx_almost_full = 1'b0;
    tick();
    checks++;
    if (data_ready !== 1'b1 || data_flat !== mkdata(0, 2)) begin
      errors++; $display("FAIL bp_resume: dr=%b data=%h, required 1 %h", data_ready, data_flat, mkdata(0, 2));
    end
    wait_acks(4, 200, ok);
    checks++;
    if (!ok || ack_q[3] != 0 || idle_q[3] != 1) begin
      errors++; $display("FAIL bp_finish: acks %p idle %p, required 4 src0 acks, last idle", ack_q, idle_q);
    end
    wait_idle("bp");
  endtask

  task automatic test_timeout();
    bit ok;
    int run;
    clear_mon();
    p_en = 1'b0;
    start_src(2, 1, 1);
    start_src(3, 1, 1);
    for (int k = 0; k < 10 && !data_ready; k++) tick();
    checks++;
    if (data_ready !== 1'b1 || grant_id !== 3'd2) begin
      errors++; $display("FAIL tmo_first: dr=%b gid=%0d, required 1 2", data_ready, grant_id);
    end
    run = 0;
    while (data_ready && run < 40) begin
      run++;
      tick();
    end
    checks++;
    if (run != 8) begin
      errors++; $display("FAIL tmo_len: data_ready high %0d cycles, required 8", run);
    end
    checks++;
    if (err_timeout !== 1'b1 || grant_valid !== 1'b0) begin
      errors++; $display("FAIL tmo_pulse: err=%b gv=%b, required 1 0", err_timeout, grant_valid);
    end
    tick();
    checks++;
    if (data_ready !== 1'b1 || grant_id !== 3'd3 || err_timeout !== 1'b0) begin
      errors++; $display("FAIL tmo_next: dr=%b gid=%0d err=%b, required 1 3 0", data_ready, grant_id, err_timeout);
    end
    checks++;
    if (tmo_cnt != 1 || ack_q.size() != 0) begin
      errors++; $display("FAIL tmo_count: pulses=%0d acks=%0d, required 1 0", tmo_cnt, ack_q.size());
    end
    p_en = 1'b1;
    wait_acks(2, 200, ok);
    checks++;
    if (!ok || ack_q[0] != 3 || ack_q[1] != 2) begin
      errors++; $display("FAIL tmo_recover: got %p, required 3 2", ack_q);
    end
    wait_idle("tmo");
  endtask

  task automatic test_reset_mid();
    bit ok;
    clear_mon();
    p_en = 1'b0;
    start_src(1, 1, 1);
    for (int k = 0; k < 10 && !data_ready; k++) tick();
    checks++;
    if (data_ready !== 1'b1 || grant_id !== 3'd1) begin
      errors++; $display("FAIL rstmid_grant: dr=%b gid=%0d, required 1 1", data_ready, grant_id);
    end
    start_src(0, 1, 1);
    rst = 1'b1;
    #1;
    checks++;
    if (data_ready !== 1'b0 || grant_valid !== 1'b0 || src_ack !== 4'b0) begin
      errors++; $display("FAIL rstmid_async: dr=%b gv=%b ack=%b, required 0 0 0000", data_ready, grant_valid, src_ack);
    end
    repeat (2) tick();
    rst = 1'b0;
    p_en = 1'b1;
    for (int k = 0; k < 10 && !data_ready; k++) tick();
    checks++;
    if (data_ready !== 1'b1 || grant_id !== 3'd0) begin
      errors++; $display("FAIL rstmid_first: dr=%b gid=%0d, required 1 0", data_ready, grant_id);
    end
    wait_acks(2, 200, ok);
    checks++;
    if (!ok || ack_q[0] != 0 || ack_q[1] != 1) begin
      errors++; $display("FAIL rstmid_order: got %p, required 0 1", ack_q);
    end
    wait_idle("rstmid");
  endtask

  initial begin
    tmo_cnt = 0; rel_cnt = 0; viol = 0; ovl = 0; bcnt = 0;
    Parsar_busy = 1'b0;
    test_reset();
    test_single();
    test_contention();
    test_burst();
    test_backpressure();
    test_timeout();
    test_reset_mid();
    checks++;
    if (viol != 0) begin
      errors++; $display("FAIL ready_while_busy: %0d long overlaps, required 0", viol);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
